alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter FAULT_LIMIT, default 3, meaning mismatches before a replica is disabled (legal range 1..7).
REQ-002 SHALL have parameter IDLE_GAP, default 4, meaning consecutive idle CPU cycles before self-test starts (legal range 1..15).
REQ-003 SHALL have parameter TEST_LEN, default 8, meaning vectors per self-test burst.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports cpu_req in 1, cpu_a in 32, cpu_b in 32, cpu_alucont in 3: the datapath ALU request.
REQ-008 SHALL have port cpu_gnt  out  1  CPU owns the ALU this cycle.
REQ-009 SHALL have ports alu_a out 32, alu_b out 32, alu_cont out 3: the operands driven to the shared ALU.
REQ-010 SHALL have port rep_result  in  128  per-replica results {r3,r2,r1,r0}.
REQ-011 SHALL have port rep_zero  in  4  per-replica zero flags.
REQ-012 SHALL have ports voted in 32 and voted_zero in 1: the majority outputs.
REQ-013 SHALL have port rep_en  out  4  replica enable mask.
REQ-014 SHALL have port fault_cnt  out  12  per-replica 3-bit counters {c3,c2,c1,c0}.
REQ-015 SHALL have port bist_active  out  1  a self-test vector is issued this cycle.
REQ-016 SHALL have port degraded  out  1  fewer than 3 replicas are enabled.

Function
REQ-017 SHALL set cpu_gnt = cpu_req combinationally; the CPU always wins, with zero-cycle latency.
REQ-018 SHALL drive alu_a/alu_b/alu_cont from cpu_* when cpu_req=1, from the test vector when bist_active=1, and zero otherwise.
REQ-019 SHALL implement FSM states IDLE and TEST; bist_active = (state==TEST) & ~cpu_req.
REQ-020 SHALL, in IDLE, count consecutive cpu_req=0 cycles in idle_cnt, clear idle_cnt on cpu_req=1, and enter TEST on the edge where idle_cnt reaches IDLE_GAP.
REQ-021 SHALL, in TEST with cpu_req=1, return to IDLE with idle_cnt=0 while holding the LFSR, vector index and op index (resume later).
REQ-022 SHALL, in TEST, return to IDLE with idle_cnt=0 and vector index=0 after TEST_LEN issued vectors.
REQ-023 SHALL form the test vector as a = 32-bit Galois LFSR (taps 0x80200003, seed 0xACE10001), b = {a[15:0],a[31:16]}, alu_cont from the op sequence 010,110,000,001,111 (wrapping).
REQ-024 SHALL advance the LFSR and op index only on edges where bist_active=1.
REQ-025 SHALL define an issued op as cpu_req | bist_active, and compare each enabled replica's result and zero flag to voted/voted_zero in that same cycle.
REQ-026 SHALL, on mismatch, increment that replica's counter at the edge, saturating at FAULT_LIMIT.
REQ-027 SHALL clear the rep_en bit on the same edge at which the counter reaches FAULT_LIMIT; a disabled replica SHALL never be compared or re-enabled except by reset.
REQ-028 SHALL count simultaneous mismatches in several replicas independently in the same cycle.
REQ-029 SHALL NOT compare or count when no op is issued.
REQ-030 SHALL assert degraded combinationally when popcount(rep_en) < 3.

Reset
REQ-031 SHALL, when reset=1 at an edge, set state=IDLE, idle_cnt=0, LFSR=seed, vector and op index=0, fault_cnt=0, rep_en=4'hF.
REQ-032 SHALL hold bist_active=0 and degraded=0 after reset; reset mid-TEST SHALL abort the burst with no partial count update.

Structure
REQ-033 SHALL place the state enum, the op-sequence constants, and the LFSR seed and taps in package alu_sched_pkg.
REQ-034 SHALL implement the LFSR as sub-module lfsr32 (inputs clk, reset, en; output 32-bit q).

Verification
REQ-035 SHALL verify: reset; cpu_req=1, a=5, b=3, alucont=010 -> cpu_gnt=1, alu_a=5, alu_b=3, bist_active=0.
REQ-036 SHALL verify: cpu_req=0 for 4 cycles -> 5th cycle bist_active=1, alu_a=0xACE10001, alu_b=0x0001ACE1, alu_cont=010.
REQ-037 SHALL verify: flip rep_result bit 64 (replica 2) on 3 issued ops -> fault_cnt[8:6]=3, rep_en=4'b1011 after the 3rd edge, no change on a 4th mismatch.
REQ-038 SHALL verify: cpu_req=1 on the 3rd test vector -> alu_a=cpu_a that cycle; after 4 idle cycles the burst resumes with the identical 3rd LFSR value.
REQ-039 SHALL verify: disable replicas 1 and 3 -> degraded=1, and replica 1/3 mismatches no longer alter fault_cnt.
REQ-040 SHALL verify: reset asserted during TEST -> next cycle rep_en=4'hF, fault_cnt=0, bist_active=0, LFSR reseeded.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM states,
// self-test op sequence and LFSR seed/taps.
package alu_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TEST = 1'b1
  } state_t;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [2:0] OP_SEQ_LEN = 3'd5;
  localparam logic [2:0] OP_SEQ_0   = 3'b010;
  localparam logic [2:0] OP_SEQ_1   = 3'b110;
  localparam logic [2:0] OP_SEQ_2   = 3'b000;
  localparam logic [2:0] OP_SEQ_3   = 3'b001;
  localparam logic [2:0] OP_SEQ_4   = 3'b111;

  function automatic logic [2:0] op_at(input logic [2:0] idx);
    case (idx)
      3'd0:    op_at = OP_SEQ_0;
      3'd1:    op_at = OP_SEQ_1;
      3'd2:    op_at = OP_SEQ_2;
      3'd3:    op_at = OP_SEQ_3;
      3'd4:    op_at = OP_SEQ_4;
      default: op_at = OP_SEQ_0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR used as the self-test operand source;
// holds its value whenever en is low.
module lfsr32
  import alu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between the CPU and an idle-time self-test engine, and
// tracks per-replica disagreement with the majority vote.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned FAULT_LIMIT = 3,
  parameter int unsigned IDLE_GAP    = 4,
  parameter int unsigned TEST_LEN    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_a,
  input  logic [31:0]  cpu_b,
  input  logic [2:0]   cpu_alucont,
  output logic         cpu_gnt,
  output logic [31:0]  alu_a,
  output logic [31:0]  alu_b,
  output logic [2:0]   alu_cont,
  input  logic [127:0] rep_result,
  input  logic [3:0]   rep_zero,
  input  logic [31:0]  voted,
  input  logic         voted_zero,
  output logic [3:0]   rep_en,
  output logic [11:0]  fault_cnt,
  output logic         bist_active,
  output logic         degraded
);

  localparam int unsigned VW = (TEST_LEN > 1) ? $clog2(TEST_LEN) : 1;

  state_t        r_state;
  logic [3:0]    r_idle_cnt;
  logic [VW-1:0] r_vec_idx;
  logic [2:0]    r_op_idx;
  logic [2:0]    r_cnt [4];
  logic [3:0]    r_rep_en;

  logic [31:0]   w_lfsr;
  logic          w_bist;
  logic          w_issued;
  logic [3:0]    w_mis;
  logic [2:0]    w_pop;

  lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (w_bist),
    .q     (w_lfsr)
  );

  assign w_bist      = (r_state == ST_TEST) && !cpu_req;
  assign w_issued    = cpu_req || w_bist;
  assign cpu_gnt     = cpu_req;
  assign bist_active = w_bist;
  assign rep_en      = r_rep_en;
  assign fault_cnt   = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
  assign w_pop       = {2'b00, r_rep_en[0]} + {2'b00, r_rep_en[1]}
                     + {2'b00, r_rep_en[2]} + {2'b00, r_rep_en[3]};
  assign degraded    = (w_pop < 3'd3);

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cont = '0;
    if (cpu_req) begin
      alu_a    = cpu_a;
      alu_b    = cpu_b;
      alu_cont = cpu_alucont;
    end else if (w_bist) begin
      alu_a    = w_lfsr;
      alu_b    = {w_lfsr[15:0], w_lfsr[31:16]};
      alu_cont = op_at(r_op_idx);
    end
  end

  always_comb begin
    w_mis = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_mis[i] = w_issued && r_rep_en[i] &&
                 ((rep_result[32*i +: 32] != voted) || (rep_zero[i] != voted_zero));
    end
  end

  // A CPU request in TEST only leaves the state; LFSR, op and vector
  // indices hold so the interrupted burst resumes where it stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
      r_vec_idx  <= '0;
      r_op_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt + 4'd1 == 4'(IDLE_GAP)) begin
            r_state    <= ST_TEST;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 4'd1;
          end
        end
        ST_TEST: begin
          if (cpu_req) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
          end else begin
            r_op_idx <= (r_op_idx == OP_SEQ_LEN - 3'd1) ? '0 : r_op_idx + 3'd1;
            if (r_vec_idx == VW'(TEST_LEN - 1)) begin
              r_state    <= ST_IDLE;
              r_vec_idx  <= '0;
              r_idle_cnt <= '0;
            end else begin
              r_vec_idx <= r_vec_idx + VW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A replica stops being compared once disabled, so its counter
  // saturates at FAULT_LIMIT without an explicit clamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_en <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_mis[i]) begin
          r_cnt[i] <= r_cnt[i] + 3'd1;
          if (r_cnt[i] + 3'd1 == 3'(FAULT_LIMIT)) begin
            r_rep_en[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios with literal expectations plus a
// randomized run, all checked each cycle against a behavioural model.
module tb_alu_sched;

  localparam int FL = 3;
  localparam int IG = 4;
  localparam int TL = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic [31:0]  cpu_a = '0;
  logic [31:0]  cpu_b = '0;
  logic [2:0]   cpu_alucont = '0;
  logic         cpu_gnt;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [2:0]   alu_cont;
  logic [127:0] rep_result = '0;
  logic [3:0]   rep_zero = '0;
  logic [31:0]  voted = '0;
  logic         voted_zero = 1'b0;
  logic [3:0]   rep_en;
  logic [11:0]  fault_cnt;
  logic         bist_active;
  logic         degraded;

  alu_sched #(
    .FAULT_LIMIT (FL),
    .IDLE_GAP    (IG),
    .TEST_LEN    (TL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_a       (cpu_a),
    .cpu_b       (cpu_b),
    .cpu_alucont (cpu_alucont),
    .cpu_gnt     (cpu_gnt),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cont    (alu_cont),
    .rep_result  (rep_result),
    .rep_zero    (rep_zero),
    .voted       (voted),
    .voted_zero  (voted_zero),
    .rep_en      (rep_en),
    .fault_cnt   (fault_cnt),
    .bist_active (bist_active),
    .degraded    (degraded)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: operands are the n-th LFSR value since reset.
  bit       m_valid = 1'b0;
  bit       m_test;
  int       m_idle;
  int       m_vec;
  int       m_n;
  int       m_cnt [4];
  bit       m_en  [4];
  logic [2:0] OPS [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  function automatic logic [31:0] lfsr_nth(input int n);
    logic [31:0] v;
    v = 32'hACE1_0001;
    for (int k = 0; k < n; k++) begin
      if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
      else      v = v >> 1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] ea, eb;
    logic [2:0]  ec;
    logic [11:0] efc;
    logic [3:0]  een;
    bit          ebist;
    int          nen;
    ebist = m_test && !cpu_req;
    ea = '0; eb = '0; ec = '0;
    if (cpu_req) begin
      ea = cpu_a; eb = cpu_b; ec = cpu_alucont;
    end else if (ebist) begin
      ea = lfsr_nth(m_n);
      eb = {ea[15:0], ea[31:16]};
      ec = OPS[m_n % 5];
    end
    nen = 0;
    for (int i = 0; i < 4; i++) begin
      efc[3*i +: 3] = 3'(m_cnt[i]);
      een[i] = m_en[i];
      nen += int'(m_en[i]);
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(cpu_req));
    chk("bist_active", 32'(bist_active), 32'(ebist));
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_cont", 32'(alu_cont), 32'(ec));
    chk("rep_en", 32'(rep_en), 32'(een));
    chk("fault_cnt", 32'(fault_cnt), 32'(efc));
    chk("degraded", 32'(degraded), 32'(nen < 3));
  endtask

  task automatic model_step();
    bit issued;
    if (reset) begin
      m_valid = 1'b1;
      m_test = 1'b0; m_idle = 0; m_vec = 0; m_n = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_en[i] = 1'b1;
      end
      return;
    end
    if (!m_valid) return;
    issued = cpu_req || m_test;
    if (issued) begin
      for (int i = 0; i < 4; i++) begin
        if (m_en[i] && ((rep_result[32*i +: 32] !== voted) || (rep_zero[i] !== voted_zero))) begin
          m_cnt[i]++;
          if (m_cnt[i] == FL) m_en[i] = 1'b0;
        end
      end
    end
    if (!m_test) begin
      if (cpu_req) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == IG) begin m_test = 1'b1; m_idle = 0; end
      end
    end else if (cpu_req) begin
      m_test = 1'b0; m_idle = 0;
    end else begin
      m_n++; m_vec++;
      if (m_vec == TL) begin m_test = 1'b0; m_vec = 0; end
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance model.
  task automatic cyc(input bit rst, input bit req, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] c, input logic [3:0] flip, input logic [3:0] zflip);
    @(negedge clk);
    reset = rst; cpu_req = req; cpu_a = a; cpu_b = b; cpu_alucont = c;
    voted = $urandom;
    voted_zero = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      rep_result[32*i +: 32] = voted ^ {31'b0, flip[i]};
    end
    rep_zero = {4{voted_zero}} ^ zflip;
    #1;
    if (m_valid) compare();
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  fl, zf;
    int          preq;

    chk("model_lfsr1", lfsr_nth(1), 32'hD650_8003);

    // Reset, then a plain CPU op.
    cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
    cyc(1'b0, 1'b1, 32'd5, 32'd3, 3'b010, '0, '0);
    chk("cpu_alu_a", alu_a, 32'd5);
    chk("cpu_alu_b", alu_b, 32'd3);
    chk("cpu_gnt_lit", 32'(cpu_gnt), 32'd1);
    chk("cpu_bist_lit", 32'(bist_active), 32'd0);
    chk("rst_rep_en", 32'(rep_en), 32'hF);
    chk("rst_fault", 32'(fault_cnt), 32'h0);
    chk("rst_degraded", 32'(degraded), 32'd0);

    // Four idle cycles, then the first self-test vector.
    idle(4);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("v1_bist", 32'(bist_active), 32'd1);
    chk("v1_a", alu_a, 32'hACE1_0001);
    chk("v1_b", alu_b, 32'h0001_ACE1);
    chk("v1_op", 32'(alu_cont), 32'(3'b010));
    cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("v2_a", alu_a, 32'hD650_8003);
    chk("v2_op", 32'(alu_cont), 32'(3'b110));

    // CPU preempts the 3rd vector; burst resumes with the same value.
    cyc(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'b001, '0, '0);
    chk("pre_a", alu_a, 32'h1234_5678);
    chk("pre_bist", 32'(bist_active), 32'd0);
    idle(4);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("v3_bist", 32'(bist_active), 32'd1);
    chk("v3_a", alu_a, 32'hEB08_4002);
    chk("v3_op", 32'(alu_cont), 32'(3'b000));

    // Replica 2 mismatches three times, then once more while disabled.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, $urandom, $urandom, 3'b010, 4'b0100, '0);
    cyc(1'b0, 1'b1, $urandom, $urandom, 3'b010, 4'b0100, '0);
    chk("r2_cnt", 32'(fault_cnt[8:6]), 32'd3);
    chk("r2_en", 32'(rep_en), 32'(4'b1011));
    cyc(1'b0, 1'b1, $urandom, $urandom, 3'b010, '0, '0);
    chk("r2_cnt_sat", 32'(fault_cnt), 32'h0C0);
    chk("r2_en_hold", 32'(rep_en), 32'(4'b1011));

    // Replicas 1 and 3 disabled together -> degraded.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, $urandom, $urandom, 3'b110, 4'b1010, '0);
    cyc(1'b0, 1'b1, $urandom, $urandom, 3'b110, 4'b1010, 4'b1010);
    chk("deg_en", 32'(rep_en), 32'(4'b0001));
    chk("deg_flag", 32'(degraded), 32'd1);
    chk("deg_cnt", 32'(fault_cnt), 32'h6D8);
    cyc(1'b0, 1'b1, $urandom, $urandom, 3'b110, '0, '0);
    chk("deg_cnt_hold", 32'(fault_cnt), 32'h6D8);

    // Reset in the middle of a burst, with a mismatch on that cycle.
    idle(4);
    cyc(1'b1, 1'b0, '0, '0, '0, 4'b0001, '0);
    chk("mid_bist", 32'(bist_active), 32'd1);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("post_rst_en", 32'(rep_en), 32'hF);
    chk("post_rst_cnt", 32'(fault_cnt), 32'h0);
    chk("post_rst_bist", 32'(bist_active), 32'd0);
    idle(3);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, '0);
    chk("reseed_a", alu_a, 32'hACE1_0001);

    // Randomized traffic with phases of busy and quiet CPU.
    cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
    preq = 2;
    for (int k = 0; k < 4000; k++) begin
      if (k % 60 == 0) preq = $urandom_range(1, 8);
      ra = $urandom; rb = $urandom;
      fl = '0; zf = '0;
      for (int i = 0; i < 4; i++) begin
        fl[i] = ($urandom_range(0, 40) == 0);
        zf[i] = ($urandom_range(0, 60) == 0);
      end
      cyc(($urandom_range(0, 700) == 0), ($urandom_range(1, preq) == 1), ra, rb,
          3'($urandom_range(0, 7)), fl, zf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
